// File: rtl/io_chan_pkg.sv
// Shared types and helpers for the io_chan_bridge pin bridge.
package io_chan_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_INVERT  = 2'd1,
    MODE_STRETCH = 2'd2,
    MODE_FORCE   = 2'd3
  } chan_mode_e;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_chan_lane.sv
// One bridge channel: synchroniser, glitch filter, edge flags, stretch counter and output mux.
module io_chan_lane
  import io_chan_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic       clk_300,
  input  logic       rst_n,
  input  logic       in,
  input  chan_mode_e mode,
  input  logic       force_val,
  input  logic       clr_flags,
  output logic       out,
  output logic       lvl,
  output logic       rise_flag,
  output logic       fall_flag
);

  localparam int SW = cnt_width(STRETCH_CYCLES);
  localparam logic [SW-1:0] ST_LOAD = SW'(STRETCH_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          filt;
  logic          filt_d;
  logic          rise;
  logic          fall;
  logic [SW-1:0] st_cnt;
  logic [SW-1:0] st_cnt_next;
  logic          out_next;

  always_ff @(posedge clk_300 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= in;
      sync_q2 <= sync_q1;
    end
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_no_filter
      assign filt = sync_q2;
    end else begin : g_filter
      localparam int FW = cnt_width(FILTER_CYCLES);
      localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);
      logic [FW-1:0] flt_cnt;
      logic          filt_q;

      // Level only follows the synchronised input after it has differed for FILTER_CYCLES cycles.
      always_ff @(posedge clk_300 or negedge rst_n) begin
        if (!rst_n) begin
          flt_cnt <= '0;
          filt_q  <= 1'b0;
        end else if (sync_q2 != filt_q) begin
          if (flt_cnt == LAST) begin
            filt_q  <= sync_q2;
            flt_cnt <= '0;
          end else begin
            flt_cnt <= flt_cnt + 1'b1;
          end
        end else begin
          flt_cnt <= '0;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  assign lvl  = filt;
  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    st_cnt_next = '0;
    out_next    = 1'b0;
    case (mode)
      MODE_PASS:   out_next = filt;
      MODE_INVERT: out_next = ~filt;
      MODE_STRETCH: begin
        // A rise (re)loads the hold counter; filt itself keeps out high for wide pulses.
        if (rise) begin
          st_cnt_next = ST_LOAD;
        end else if (st_cnt != '0) begin
          st_cnt_next = st_cnt - 1'b1;
        end
        out_next = filt | rise | (st_cnt != '0);
      end
      MODE_FORCE:  out_next = force_val;
      default:     out_next = filt;
    endcase
  end

  // Set takes priority over clear so an edge coinciding with a clear is kept.
  always_ff @(posedge clk_300 or negedge rst_n) begin
    if (!rst_n) begin
      filt_d    <= 1'b0;
      st_cnt    <= '0;
      out       <= 1'b0;
      rise_flag <= 1'b0;
      fall_flag <= 1'b0;
    end else begin
      filt_d    <= filt;
      st_cnt    <= st_cnt_next;
      out       <= out_next;
      rise_flag <= rise | (rise_flag & ~clr_flags);
      fall_flag <= fall | (fall_flag & ~clr_flags);
    end
  end

endmodule

// File: rtl/io_chan_bridge.sv
// N-channel board pin bridge: one io_chan_lane per pin pair plus a registered interrupt reduce.
module io_chan_bridge
  import io_chan_pkg::*;
#(
  parameter int N_CHAN         = 5,
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic                   clk_300,
  input  logic                   rst_n,
  input  logic [N_CHAN-1:0]      in,
  output logic [N_CHAN-1:0]      out,
  input  logic [N_CHAN-1:0][1:0] mode,
  input  logic [N_CHAN-1:0]      force_val,
  output logic [N_CHAN-1:0]      lvl,
  output logic [N_CHAN-1:0]      rise_flag,
  output logic [N_CHAN-1:0]      fall_flag,
  input  logic [N_CHAN-1:0]      clr_flags,
  input  logic [N_CHAN-1:0]      irq_en,
  output logic                   irq
);

  generate
    for (genvar i = 0; i < N_CHAN; i++) begin : g_lane
      io_chan_lane #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .STRETCH_CYCLES(STRETCH_CYCLES)
      ) u_lane (
        .clk_300  (clk_300),
        .rst_n    (rst_n),
        .in       (in[i]),
        .mode     (chan_mode_e'(mode[i])),
        .force_val(force_val[i]),
        .clr_flags(clr_flags[i]),
        .out      (out[i]),
        .lvl      (lvl[i]),
        .rise_flag(rise_flag[i]),
        .fall_flag(fall_flag[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_300 or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |((rise_flag | fall_flag) & irq_en);
    end
  end

endmodule

// File: tb/tb_io_chan_bridge.sv
// Directed bench for io_chan_bridge: a filtered (F=4) five-channel instance and an unfiltered stretch instance.
module tb_io_chan_bridge;
  import io_chan_pkg::*;

  logic           clk_300 = 1'b0;
  logic           rst_n;
  logic [4:0]     in;
  logic [4:0]     out;
  logic [4:0][1:0] mode;
  logic [4:0]     force_val;
  logic [4:0]     lvl;
  logic [4:0]     rise_flag;
  logic [4:0]     fall_flag;
  logic [4:0]     clr_flags;
  logic [4:0]     irq_en;
  logic           irq;

  logic [0:0]      in0;
  logic [0:0]      out0;
  logic [0:0][1:0] mode0;
  logic [0:0]      force0;
  logic [0:0]      lvl0;
  logic [0:0]      rise0;
  logic [0:0]      fall0;
  logic [0:0]      clr0;
  logic [0:0]      irq_en0;
  logic            irq0;

  int checks = 0;
  int errors = 0;

  always #5 clk_300 = ~clk_300;

  io_chan_bridge #(.N_CHAN(5), .FILTER_CYCLES(4), .STRETCH_CYCLES(8)) dut (
    .clk_300(clk_300), .rst_n(rst_n), .in(in), .out(out), .mode(mode), .force_val(force_val),
    .lvl(lvl), .rise_flag(rise_flag), .fall_flag(fall_flag), .clr_flags(clr_flags),
    .irq_en(irq_en), .irq(irq)
  );

  io_chan_bridge #(.N_CHAN(1), .FILTER_CYCLES(0), .STRETCH_CYCLES(8)) dut0 (
    .clk_300(clk_300), .rst_n(rst_n), .in(in0), .out(out0), .mode(mode0), .force_val(force0),
    .lvl(lvl0), .rise_flag(rise0), .fall_flag(fall0), .clr_flags(clr0),
    .irq_en(irq_en0), .irq(irq0)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_300);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives a pulse of 'width' input cycles plus an optional 1-cycle retrigger at 'gap' on dut0.
  task automatic stretch_run(input int width, input int gap, output int first, output int last,
                             output int ones);
    first = -1;
    last  = -1;
    ones  = 0;
    for (int c = 0; c < 30; c++) begin
      in0[0] = (c < width) || (c == gap);
      tick(1);
      if (out0[0] === 1'b1) begin
        ones++;
        if (first < 0) first = c;
        last = c;
      end
    end
    in0 = '0;
  endtask

  initial begin
    int first, last, ones;
    logic seen;

    rst_n     = 1'b0;
    in        = '0;
    mode      = '0;
    force_val = '0;
    clr_flags = '0;
    irq_en    = '0;
    in0       = '0;
    mode0     = '0;
    force0    = '0;
    clr0      = '0;
    irq_en0   = '0;

    #2;
    check_output("reset_out",  32'(out), 32'h0);
    check_output("reset_lvl",  32'(lvl), 32'h0);
    check_output("reset_flag", 32'({rise_flag, fall_flag}), 32'h0);
    check_output("reset_irq",  32'(irq), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    $display("[TB] pass mode latency on ch0");
    in[0] = 1'b1;
    tick(5);
    check_output("pass_lvl_early", 32'(lvl[0]), 32'h0);
    tick(1);
    check_output("pass_lvl", 32'(lvl[0]), 32'h1);
    check_output("pass_out_early", 32'(out[0]), 32'h0);
    tick(1);
    check_output("pass_out", 32'(out[0]), 32'h1);
    check_output("pass_rise_flag", 32'(rise_flag[0]), 32'h1);

    $display("[TB] glitch filter on ch1");
    seen = 1'b0;
    in[1] = 1'b1;
    tick(3);
    in[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | lvl[1] | out[1] | rise_flag[1] | fall_flag[1];
    end
    check_output("glitch_dropped", 32'(seen), 32'h0);
    in[1] = 1'b1;
    tick(4);
    in[1] = 1'b0;
    tick(2);
    check_output("pulse4_lvl", 32'(lvl[1]), 32'h1);
    tick(1);
    check_output("pulse4_rise", 32'(rise_flag[1]), 32'h1);
    tick(3);
    check_output("pulse4_lvl_fall", 32'(lvl[1]), 32'h0);
    tick(1);
    check_output("pulse4_fall", 32'(fall_flag[1]), 32'h1);

    $display("[TB] flags and irq on ch2");
    irq_en = 5'b00100;
    in[2]  = 1'b1;
    tick(6);
    check_output("irq_flag_early", 32'(rise_flag[2]), 32'h0);
    tick(1);
    check_output("irq_flag_set", 32'(rise_flag[2]), 32'h1);
    check_output("irq_not_yet", 32'(irq), 32'h0);
    tick(1);
    check_output("irq_set", 32'(irq), 32'h1);
    clr_flags[2] = 1'b1;
    tick(1);
    clr_flags[2] = 1'b0;
    check_output("clr_flag", 32'(rise_flag[2]), 32'h0);
    check_output("clr_irq_lag", 32'(irq), 32'h1);
    tick(1);
    check_output("clr_irq", 32'(irq), 32'h0);
    in[2] = 1'b0;
    tick(8);
    check_output("ch2_fall_flag", 32'(fall_flag[2]), 32'h1);
    in[2] = 1'b1;
    tick(6);
    clr_flags[2] = 1'b1;
    tick(1);
    clr_flags[2] = 1'b0;
    check_output("clr_vs_set_rise", 32'(rise_flag[2]), 32'h1);
    check_output("clr_vs_set_fall", 32'(fall_flag[2]), 32'h0);

    $display("[TB] force and invert on ch3");
    mode[3]      = MODE_FORCE;
    force_val[3] = 1'b1;
    check_output("force_not_yet", 32'(out[3]), 32'h0);
    tick(1);
    check_output("force_out", 32'(out[3]), 32'h1);
    mode[3] = MODE_INVERT;
    tick(1);
    check_output("invert_low_in", 32'(out[3]), 32'h1);
    in[3] = 1'b1;
    tick(6);
    check_output("invert_before_lat", 32'(out[3]), 32'h1);
    tick(1);
    check_output("invert_after_lat", 32'(out[3]), 32'h0);
    check_output("invert_rise_flag", 32'(rise_flag[3]), 32'h1);

    $display("[TB] stretch on unfiltered instance");
    mode0[0] = MODE_STRETCH;
    tick(2);
    stretch_run(1, -1, first, last, ones);
    check_output("stretch1_first", 32'(first), 32'd2);
    check_output("stretch1_ones", 32'(ones), 32'd8);
    check_output("stretch1_last", 32'(last), 32'd9);
    stretch_run(12, -1, first, last, ones);
    check_output("stretch12_first", 32'(first), 32'd2);
    check_output("stretch12_ones", 32'(ones), 32'd12);
    check_output("stretch12_last", 32'(last), 32'd13);
    stretch_run(1, 5, first, last, ones);
    check_output("retrig_ones", 32'(ones), 32'd13);
    check_output("retrig_last", 32'(last), 32'd14);

    $display("[TB] reset mid-stretch");
    mode[4] = MODE_STRETCH;
    in[4]   = 1'b1;
    tick(5);
    in[4] = 1'b0;
    tick(3);
    check_output("pre_reset_out4", 32'(out[4]), 32'h1);
    check_output("pre_reset_irq", 32'(irq), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_out", 32'(out), 32'h0);
    check_output("async_rst_lvl", 32'(lvl), 32'h0);
    check_output("async_rst_flags", 32'({rise_flag, fall_flag}), 32'h0);
    check_output("async_rst_irq", 32'(irq), 32'h0);
    in        = 5'b11111;
    mode      = '0;
    force_val = '0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check_output("rel_lvl", 32'(lvl), 32'h1f);
    check_output("rel_flag_early", 32'(rise_flag), 32'h0);
    tick(1);
    check_output("rel_rise_flag", 32'(rise_flag), 32'h1f);
    check_output("rel_out", 32'(out), 32'h1f);
    tick(1);
    check_output("rel_irq", 32'(irq), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
